// File: rtl/balun_rx_combiner.sv
// rtl/balun_rx_combiner.sv - P/N leg re-alignment, (P-N)/2 combine, DC offset calibration and removal

// Per-leg skew FIFO: registered ready, no write-through, simultaneous push/pop allowed
module balun_rx_skew_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  output logic         wr_ready,
  input  logic         rd_pop,
  output logic         rd_nonempty,
  output logic [W-1:0] rd_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          wr_en, rd_en;

  // Next-state for storage, pointers and occupancy; ready follows the next occupancy
  always_comb begin
    wr_en  = wr_valid && ready_q;
    rd_en  = rd_pop && (cnt_q != '0);
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_en) begin
      mem_d[wptr_q] = wr_data;
      wptr_d        = wptr_q + 1'b1;
    end
    if (rd_en) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d != FULL_CNT);
  end

  // Sample storage carries no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer, occupancy and ready registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign wr_ready    = ready_q;
  assign rd_nonempty = (cnt_q != '0);
  assign rd_data     = mem_q[rptr_q];
endmodule

module balun_rx_combiner #(
  parameter int W          = 12,
  parameter int SKEW_DEPTH = 4,
  parameter int CAL_LOG2   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         p_valid,
  input  logic [W-1:0] p_data,
  output logic         p_ready,
  input  logic         n_valid,
  input  logic [W-1:0] n_data,
  output logic         n_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_sat,
  input  logic         out_ready,
  input  logic         cal_start,
  output logic         cal_busy,
  output logic         cal_done,
  output logic [W-1:0] offset
);
  localparam int ACC_W = W + CAL_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_LOAD
  } state_t;

  logic [W-1:0]        p_head, n_head;
  logic                p_nonempty, n_nonempty;
  logic                consumer_ready;
  logic                pop;

  logic [W:0]          diff;
  logic [W-1:0]        half;
  logic [W:0]          corr;
  logic [W-1:0]        sat_data;
  logic                sat_flag;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CAL_LOG2-1:0] cal_cnt_q, cal_cnt_d;
  logic [W-1:0]        offset_q, offset_d;
  logic                cal_busy_q, cal_busy_d;
  logic                cal_done_q, cal_done_d;
  logic                out_valid_q, out_valid_d;
  logic [W-1:0]        out_data_q, out_data_d;
  logic                out_sat_q, out_sat_d;

  balun_rx_skew_fifo #(.W(W), .DEPTH(SKEW_DEPTH)) u_p_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (p_valid),
    .wr_data     (p_data),
    .wr_ready    (p_ready),
    .rd_pop      (pop),
    .rd_nonempty (p_nonempty),
    .rd_data     (p_head)
  );

  balun_rx_skew_fifo #(.W(W), .DEPTH(SKEW_DEPTH)) u_n_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (n_valid),
    .wr_data     (n_data),
    .wr_ready    (n_ready),
    .rd_pop      (pop),
    .rd_nonempty (n_nonempty),
    .rd_data     (n_head)
  );

  // Pair pop: both legs present and the current consumer (output reg or accumulator) can take it
  always_comb begin
    case (state_q)
      ST_IDLE:  consumer_ready = !out_valid_q || out_ready;
      ST_ACCUM: consumer_ready = 1'b1;
      default:  consumer_ready = 1'b0;
    endcase
    pop = p_nonempty && n_nonempty && consumer_ready;
  end

  // Combine: h = (p - n) >>> 1 always fits W bits; y = h - offset is clipped back to W bits
  always_comb begin
    diff     = {p_head[W-1], p_head} - {n_head[W-1], n_head};
    half     = diff[W:1];
    corr     = {half[W-1], half} - {offset_q[W-1], offset_q};
    sat_flag = (corr[W] != corr[W-1]);
    if (!sat_flag) begin
      sat_data = corr[W-1:0];
    end else if (corr[W]) begin
      sat_data = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat_data = {1'b0, {(W-1){1'b1}}};
    end
  end

  // Calibration FSM and output register next-state
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cal_cnt_d   = cal_cnt_q;
    offset_d    = offset_q;
    cal_busy_d  = cal_busy_q;
    cal_done_d  = 1'b0;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          out_valid_d = 1'b1;
          out_data_d  = sat_data;
          out_sat_d   = sat_flag;
        end
        if (cal_start) begin
          state_d    = ST_ACCUM;
          acc_d      = '0;
          cal_cnt_d  = '0;
          cal_busy_d = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (pop) begin
          acc_d     = acc_q + {{CAL_LOG2{half[W-1]}}, half};
          cal_cnt_d = cal_cnt_q + 1'b1;
          if (cal_cnt_q == '1) begin
            state_d    = ST_LOAD;
            cal_done_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        offset_d   = acc_q[ACC_W-1:CAL_LOG2];
        cal_busy_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cal_cnt_q   <= '0;
      offset_q    <= '0;
      cal_busy_q  <= 1'b0;
      cal_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cal_cnt_q   <= cal_cnt_d;
      offset_q    <= offset_d;
      cal_busy_q  <= cal_busy_d;
      cal_done_q  <= cal_done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign cal_busy  = cal_busy_q;
  assign cal_done  = cal_done_q;
  assign offset    = offset_q;
endmodule

// File: tb/tb_balun_rx_combiner.sv
// tb/tb_balun_rx_combiner.sv - scoreboard bench for balun_rx_combiner
module tb_balun_rx_combiner;
  localparam int W          = 12;
  localparam int SKEW_DEPTH = 4;
  localparam int CAL_LOG2   = 4;
  localparam int CAL_PAIRS  = 1 << CAL_LOG2;
  localparam int S_MAX      = (1 << (W - 1)) - 1;
  localparam int S_MIN      = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         p_valid, n_valid, p_ready, n_ready;
  logic [W-1:0] p_data, n_data, out_data, offset;
  logic         out_valid, out_sat, out_ready;
  logic         cal_start, cal_busy, cal_done;

  always #5 clk = ~clk;

  balun_rx_combiner #(.W(W), .SKEW_DEPTH(SKEW_DEPTH), .CAL_LOG2(CAL_LOG2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_valid   (p_valid),
    .p_data    (p_data),
    .p_ready   (p_ready),
    .n_valid   (n_valid),
    .n_data    (n_data),
    .n_ready   (n_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_ready (out_ready),
    .cal_start (cal_start),
    .cal_busy  (cal_busy),
    .cal_done  (cal_done),
    .offset    (offset)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_d_q[$];
  int exp_s_q[$];
  int pq[$];
  int nq[$];
  int model_off = 0;
  int cal_left  = 0;
  int cal_acc   = 0;
  int done_cnt  = 0;
  bit held_v    = 1'b0;
  int held_d    = 0;
  int held_s    = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  function automatic int sval(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // Reference model fed by observed handshakes; checks outputs in order
  task automatic monitor_step();
    int p, n, h, y, s;
    if (!rst_n) begin
      exp_d_q.delete(); exp_s_q.delete(); pq.delete(); nq.delete();
      model_off = 0; cal_left = 0; cal_acc = 0; held_v = 1'b0;
      return;
    end
    if (held_v) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", sval(out_data), held_d);
      check("hold_sat", int'(out_sat), held_s);
    end
    if (out_valid && out_ready) begin
      if (exp_d_q.size() == 0) begin
        check("spurious_out", sval(out_data), 99999);
      end else begin
        check("out_data", sval(out_data), exp_d_q.pop_front());
        check("out_sat", int'(out_sat), exp_s_q.pop_front());
      end
    end
    held_v = out_valid && !out_ready;
    held_d = sval(out_data);
    held_s = int'(out_sat);
    if (cal_done) done_cnt++;
    if (cal_start && cal_left == 0) begin
      cal_left = CAL_PAIRS;
      cal_acc  = 0;
    end
    if (p_valid && p_ready) pq.push_back(sval(p_data));
    if (n_valid && n_ready) nq.push_back(sval(n_data));
    while (pq.size() > 0 && nq.size() > 0) begin
      p = pq.pop_front();
      n = nq.pop_front();
      h = (p - n) >>> 1;
      if (cal_left > 0) begin
        cal_acc += h;
        cal_left--;
        if (cal_left == 0) model_off = cal_acc >>> CAL_LOG2;
      end else begin
        y = h - model_off;
        s = 0;
        if (y > S_MAX) begin y = S_MAX; s = 1; end
        if (y < S_MIN) begin y = S_MIN; s = 1; end
        exp_d_q.push_back(y);
        exp_s_q.push_back(s);
      end
    end
  endtask

  // Called at posedge+1; holds valid for one edge once the selected legs are ready
  task automatic send(input bit dp, input bit dn, input int pv, input int nv);
    int g = 0;
    while (!((!dp || p_ready) && (!dn || n_ready)) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("send_guard", int'(g < 100), 1);
    p_valid = dp; n_valid = dn;
    p_data = W'(pv); n_data = W'(nv);
    @(posedge clk); #1;
    p_valid = 1'b0; n_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_d_q.size() != 0 || out_valid) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain", exp_d_q.size(), 0);
  endtask

  task automatic cal_run(input int pv, input int exp_off);
    int d0 = done_cnt;
    int g  = 0;
    cal_start = 1'b1;
    @(posedge clk); #1;
    cal_start = 1'b0;
    check("cal_busy_set", int'(cal_busy), 1);
    repeat (CAL_PAIRS) send(1'b1, 1'b1, pv, 0);
    while (!cal_done && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("cal_done_seen", int'(cal_done), 1);
    @(posedge clk); #1;
    check("cal_done_pulse", int'(cal_done), 0);
    check("cal_busy_clr", int'(cal_busy), 0);
    check("cal_offset", sval(offset), exp_off);
    @(negedge clk);
    check("cal_done_count", done_cnt - d0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    p_valid = 1'b0; n_valid = 1'b0; p_data = '0; n_data = '0;
    out_ready = 1'b1; cal_start = 1'b0; rst_n = 1'b0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_p_ready", int'(p_ready), 1);
    check("rst_n_ready", int'(n_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", sval(out_data), 0);
    check("rst_offset", sval(offset), 0);
    check("rst_cal_busy", int'(cal_busy), 0);
    check("rst_cal_done", int'(cal_done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(1'b1, 1'b1, 100, -100);
    @(negedge clk);
    check("lat_early", int'(out_valid), 0);
    @(negedge clk);
    check("lat_out", int'(out_valid), 1);
    check("lat_data", sval(out_data), 100);
    @(posedge clk); #1;
    send(1'b1, 1'b1, 7, 0);
    send(1'b1, 1'b1, -7, 0);
    drain();

    for (int i = 1; i <= 4; i++) send(1'b1, 1'b0, 10 * i, 0);
    check("skew_p_full", int'(p_ready), 0);
    check("skew_n_ready", int'(n_ready), 1);
    for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 0, 0);
    drain();
    check("skew_p_back", int'(p_ready), 1);

    cal_run(40, 20);
    send(1'b1, 1'b1, 40, 0);
    send(1'b1, 1'b1, -2048, 2047);
    drain();

    cal_run(-40, -20);
    send(1'b1, 1'b1, 2047, -2048);
    send(1'b1, 1'b1, 300, 100);
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(1'b1, 1'b1, int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
    check("bp_p_ready", int'(p_ready), 0);
    check("bp_n_ready", int'(n_ready), 0);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++)
      send(1'b1, 1'b1, int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
    drain();

    d0 = done_cnt;
    cal_start = 1'b1;
    @(posedge clk); #1;
    cal_start = 1'b0;
    repeat (5) send(1'b1, 1'b1, 40, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_offset", sval(offset), 0);
    check("mrst_cal_busy", int'(cal_busy), 0);
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_p_ready", int'(p_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_no_done", done_cnt - d0, 0);
    check("mrst_idle_busy", int'(cal_busy), 0);
    send(1'b1, 1'b1, 40, 0);
    drain();

    check("final_empty", exp_d_q.size() + pq.size() + nq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
